// File: rtl/VX_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : VX_gpu_pkg
// Brief    : Commit payload type, buffer state encoding and thread popcount
//            shared by the commit and writeback path.
// Revision : 1.0
// ============================================================================
package VX_gpu_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NW_WIDTH    = 2;
    localparam int NR_WIDTH    = 6;
    localparam int PC_WIDTH    = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int TCNT_WIDTH  = $clog2(NUM_THREADS + 1);

    typedef struct packed {
        logic [NW_WIDTH-1:0]                    wid;
        logic [NUM_THREADS-1:0]                 tmask;
        logic [PC_WIDTH-1:0]                    pc;
        logic                                   wb;
        logic [NR_WIDTH-1:0]                    rd;
        logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] data;
        logic                                   sop;
        logic                                   eop;
    } commit_data_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic [TCNT_WIDTH-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
        logic [TCNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cnt = cnt + TCNT_WIDTH'(mask[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_commit_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_arb_if
// Brief    : Per-slot commit bus: unit-side request streams, registered
//            winner stream and retirement counters.
// Revision : 1.0
// ============================================================================
interface vx_commit_arb_if
    import VX_gpu_pkg::*;
#(
    parameter int NUM_UNITS = 4
) ();

    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0]               in_valid;
    commit_data_t [NUM_UNITS-1:0]       in_data;
    logic [NUM_UNITS-1:0]               in_ready;
    logic                               out_valid;
    commit_data_t                       out_data;
    logic [UNIT_W-1:0]                  out_unit;
    logic                               out_ready;
    logic [63:0]                        perf_instrs;
    logic [63:0]                        perf_threads;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_unit, perf_instrs, perf_threads
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_unit, perf_instrs, perf_threads
    );

endinterface
`default_nettype wire

// File: rtl/vx_commit_elastic_buf.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_elastic_buf
// Brief    : Two-entry FIFO-ordered elastic buffer holding commit payloads
//            and the originating unit index.
// Revision : 1.0
// ============================================================================
module vx_commit_elastic_buf
    import VX_gpu_pkg::*;
#(
    parameter int UNIT_W = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               push_valid,
    input  wire commit_data_t       push_data,
    input  wire logic [UNIT_W-1:0]  push_unit,
    output logic                    push_ready,
    output logic                    pop_valid,
    output commit_data_t            pop_data,
    output logic [UNIT_W-1:0]       pop_unit,
    input  wire logic               pop_ready
);

    buf_state_e         state;
    buf_state_e         state_next;
    commit_data_t       mem_data [2];
    logic [UNIT_W-1:0]  mem_unit [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push;
    logic               pop;

    // Readiness depends only on occupancy, never on the downstream accept.
    always_comb begin
        push_ready = (state != BUF_FULL);
        pop_valid  = (state != BUF_EMPTY);
        push       = push_valid && push_ready;
        pop        = pop_valid && pop_ready;
        state_next = state;
        case (state)
            BUF_EMPTY: if (push) state_next = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_next = BUF_FULL;
                else if (!push && pop) state_next = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= BUF_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_unit[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_unit[wr_ptr] <= push_unit;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign pop_data = mem_data[rd_ptr];
    assign pop_unit = mem_unit[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vx_commit_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_arb
// Brief    : Round-robin commit arbiter for one issue slot with a registered
//            two-entry output stage and retirement performance counters.
// Revision : 1.0
// ============================================================================
module vx_commit_arb
    import VX_gpu_pkg::*;
#(
    parameter int NUM_UNITS = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    vx_commit_arb_if.slave  bus
);

    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [UNIT_W-1:0]  rr_ptr;
    logic [UNIT_W-1:0]  winner;
    logic               any_valid;
    logic               buf_ready;
    logic               grant;
    logic               count_eop;
    logic [63:0]        instr_count;
    logic [63:0]        thread_count;

    // First valid unit scanning upward from rr_ptr, wrapping at NUM_UNITS.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = rr_ptr;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_UNITS) begin
                idx = idx - NUM_UNITS;
            end
            if (!any_valid && bus.in_valid[UNIT_W'(idx)]) begin
                any_valid = 1'b1;
                winner    = UNIT_W'(idx);
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (reset && buf_ready && any_valid) begin
            bus.in_ready[winner] = 1'b1;
        end
    end

    assign grant = reset && buf_ready && any_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == UNIT_W'(NUM_UNITS - 1)) ? '0 : winner + 1'b1;
        end
    end

    vx_commit_elastic_buf #(
        .UNIT_W (UNIT_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push_valid (any_valid),
        .push_data  (bus.in_data[winner]),
        .push_unit  (winner),
        .push_ready (buf_ready),
        .pop_valid  (bus.out_valid),
        .pop_data   (bus.out_data),
        .pop_unit   (bus.out_unit),
        .pop_ready  (bus.out_ready)
    );

    // Only the last beat of an instruction retires it.
    assign count_eop = bus.out_valid && bus.out_ready && bus.out_data.eop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_count  <= '0;
            thread_count <= '0;
        end else begin
            instr_count  <= instr_count + 64'(count_eop);
            thread_count <= thread_count
                          + (count_eop ? 64'(popcount(bus.out_data.tmask)) : 64'd0);
        end
    end

    assign bus.perf_instrs  = instr_count;
    assign bus.perf_threads = thread_count;

endmodule
`default_nettype wire
